// File: rtl/fpu_stack_index_arbiter_pkg.sv
// fpu_stack_index_arbiter_pkg: shared FPU arbiter types and requester IDs
package fpu_stack_index_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef logic [1:0] req_id_t;
  typedef logic [2:0] stk_idx_t;
  localparam req_id_t REQ_DECODE = 2'd0;
  localparam req_id_t REQ_USEQ = 2'd1;
  localparam req_id_t REQ_EXC = 2'd2;
  localparam req_id_t REQ_LSU = 2'd3;
endpackage

// File: rtl/fpu_stack_index_arbiter_rr_pick4.sv
// rr_pick4: round-robin pick of the first request after last_winner
module rr_pick4
  import fpu_stack_index_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_winner,
  output logic [1:0] winner,
  output logic       any
);
  req_id_t c;
  // scan farthest-first so the nearest set bit after last_winner wins
  always_comb begin
    winner = last_winner;
    c = last_winner;
    for (int k = 3; k >= 1; k--) begin
      c = last_winner + 2'(k);
      winner = req[c] ? c : winner;
    end
  end
  assign any = |req;
endmodule

// File: rtl/fpu_stack_index_arbiter.sv
// fpu_stack_index_arbiter: round-robin arbiter for the FPU register-file index port
module fpu_stack_index_arbiter
  import fpu_stack_index_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [2:0] idx0,
  input  logic [2:0] idx1,
  input  logic [2:0] idx2,
  input  logic [2:0] idx3,
  output logic [1:0] sel,
  output logic [2:0] rf_idx,
  output logic       rf_en,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic       busy
);
  state_t state;
  logic [3:0] cnt;
  req_id_t last_winner, winner;
  logic any;
  stk_idx_t idx_w;
  rr_pick4 u_pick (
    .req(req),
    .last_winner(last_winner),
    .winner(winner),
    .any(any)
  );
  always_comb idx_w = winner == 2'd0 ? idx0 : winner == 2'd1 ? idx1 : winner == 2'd2 ? idx2 : idx3;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      rf_idx <= '0;
      rf_en <= 1'b0;
      gnt <= '0;
      done <= '0;
      busy <= 1'b0;
      last_winner <= REQ_LSU;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          sel <= winner;
          rf_idx <= idx_w;
          gnt <= 4'b0001 << winner;
          rf_en <= 1'b1;
          busy <= 1'b1;
          cnt <= 4'(ACCESS_CYCLES - 1);
          state <= ACCESS;
        end
        ACCESS: if (cnt == 4'd0) begin
          done <= gnt;
          gnt <= '0;
          rf_en <= 1'b0;
          last_winner <= sel;
          state <= DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        DONE: begin
          done <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_stack_index_arbiter.sv
// tb_fpu_stack_index_arbiter: scoreboard bench with a transaction-level round-robin model
module tb_fpu_stack_index_arbiter;
  localparam int AC = 2;
  typedef struct {
    int w;
    logic [2:0] idx;
    int e;
  } txn_t;
  logic clk = 0;
  logic reset = 1;
  logic [3:0] req = '0;
  logic [3:0] req1v = '0;
  logic [2:0] idx [4];
  logic [1:0] sel, sel1;
  logic [2:0] rf_idx, rf_idx1;
  logic rf_en, rf_en1, busy, busy1;
  logic [3:0] gnt, done, gnt1, done1;
  int n_chk = 0;
  int n_fail = 0;
  txn_t exp_q [$];
  int edge_n = 0;
  int ptr = 3;
  int next_free = 0;
  logic act = 0;
  txn_t cur;
  int en_cnt = 0;

  always #5 clk = ~clk;

  fpu_stack_index_arbiter #(.ACCESS_CYCLES(AC)) u_dut (
    .clk(clk), .reset(reset), .req(req),
    .idx0(idx[0]), .idx1(idx[1]), .idx2(idx[2]), .idx3(idx[3]),
    .sel(sel), .rf_idx(rf_idx), .rf_en(rf_en), .gnt(gnt), .done(done), .busy(busy)
  );
  fpu_stack_index_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1v),
    .idx0(idx[0]), .idx1(idx[1]), .idx2(idx[2]), .idx3(idx[3]),
    .sel(sel1), .rf_idx(rf_idx1), .rf_en(rf_en1), .gnt(gnt1), .done(done1), .busy(busy1)
  );

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // reference: arbiter is free once the previous grant's slot (AC+2 edges) has elapsed
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr = 3;
      next_free = 0;
      exp_q.delete();
    end else begin
      edge_n++;
      if (edge_n >= next_free && req != 0) begin
        int w;
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (ptr + k) % 4;
          if (w < 0 && req[j]) w = j;
        end
        exp_q.push_back('{w, idx[w], edge_n});
        ptr = w;
        next_free = edge_n + AC + 2;
      end
    end
  end

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      act = 0;
    end else begin
      chk("gnt_done_excl", int'(gnt != 0 && done != 0), 0);
      chk("onehot", int'($onehot0(gnt) && $onehot0(done)), 1);
      chk("busy", int'(busy), int'(gnt != 0 || done != 0));
      chk("rf_en", int'(rf_en), int'(gnt != 0));
      if (!act) begin
        if (done != 0) chk("spurious_done", int'(done), 0);
        if (gnt != 0) begin
          if (exp_q.size() == 0) chk("unexpected_gnt", int'(gnt), 0);
          else begin
            cur = exp_q.pop_front();
            act = 1;
            en_cnt = 1;
            chk("grant", int'(gnt), 1 << cur.w);
            chk("sel", int'(sel), cur.w);
            chk("rf_idx", int'(rf_idx), int'(cur.idx));
            chk("grant_edge", edge_n, cur.e);
          end
        end
      end else if (done != 0) begin
        chk("done", int'(done), 1 << cur.w);
        chk("done_edge", edge_n, cur.e + AC);
        chk("rf_en_len", en_cnt, AC);
        act = 0;
      end else begin
        chk("gnt_hold", int'(gnt), 1 << cur.w);
        chk("sel_hold", int'(sel), cur.w);
        chk("rf_idx_hold", int'(rf_idx), int'(cur.idx));
        en_cnt += int'(rf_en);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic hold_until_done;
    for (int t = 0; t < 40 && req != 0; t++) begin
      tick();
      for (int i = 0; i < 4; i++) if (done[i]) req[i] = 1'b0;
    end
    chk("hold_timeout", int'(req), 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) idx[i] = '0;
    #3;
    chk("rst_sel", int'(sel), 0);
    chk("rst_rf_idx", int'(rf_idx), 0);
    chk("rst_outs", int'({rf_en, gnt, done, busy}), 0);
    repeat (2) @(posedge clk);
    #2 reset = 0;
    idx[0] = 3'd5;
    req = 4'b0001;
    hold_until_done();
    repeat (2) tick();
    for (int i = 0; i < 4; i++) idx[i] = 3'(i + 1);
    req = 4'b1111;
    repeat (5 * (AC + 2)) tick();
    req = '0;
    repeat (AC + 3) tick();
    req = 4'b0100;
    hold_until_done();
    req = 4'b0101;
    hold_until_done();
    repeat (2) tick();
    idx[1] = 3'd6;
    req = 4'b0010;
    tick();
    idx[1] = 3'd0;
    hold_until_done();
    repeat (2) tick();
    req = 4'b0001;
    tick();
    tick();
    #5 reset = 1;
    #1;
    chk("midrst_outs", int'({rf_en, gnt, done, busy}), 0);
    chk("midrst_sel_idx", int'({sel, rf_idx}), 0);
    req = '0;
    @(posedge clk);
    #2 reset = 0;
    req = 4'b1000;
    hold_until_done();
    req = 4'b0001;
    hold_until_done();
    repeat (2) tick();
    req1v = 4'b0001;
    tick();
    chk("ac1_grant", int'({gnt1, rf_en1, busy1}), 'b0001_1_1);
    req1v = '0;
    tick();
    chk("ac1_done", int'({gnt1, done1, rf_en1}), 'b0000_0001_0);
    tick();
    chk("ac1_idle", int'({done1, busy1}), 0);
    tick();
    chk("ac1_no_regrant", int'(gnt1), 0);
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (done[i]) req[i] = 1'($urandom_range(0, 1));
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 1) == 1) idx[i] = 3'($urandom);
      end
    end
    req = '0;
    repeat (AC + 4) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("inflight", int'(act), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
